// File: rtl/nabp_filtered_ram_swap_control.sv
// Two-bank projection buffer between the ramp filter and the back-projector.
// Optional macro NABP_FR_RANGE_CHECK_EN: read addresses outside 0..kDepth-1 return 0.
module nabp_filtered_ram_swap_control #(
    parameter int kDataW      = 12,
    parameter int kSW         = 10,
    parameter int kDepth      = 512,
    parameter int kAngleW     = 8,
    parameter int kNoOfAngles = 180
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [kDataW-1:0]        fl_val,
    input  logic                     fl_valid,
    output logic                     fl_ready,
    output logic [kAngleW-1:0]       pr_angle,
    output logic                     pr_has_next_angle,
    input  logic                     pr_next_angle,
    output logic                     pr_next_angle_ack,
    input  logic                     pr_prev_angle_release,
    output logic                     pr_prev_angle_release_ack,
    input  logic signed [kSW-1:0]    pr0_s_val,
    input  logic signed [kSW-1:0]    pr1_s_val,
    output logic signed [kDataW-1:0] pr0_val,
    output logic signed [kDataW-1:0] pr1_val
);
    localparam int kAW = $clog2(kDepth);
    localparam logic [kAW-1:0]     kLastAddr  = kAW'(kDepth - 1);
    localparam logic [kAngleW-1:0] kLastAngle = kAngleW'(kNoOfAngles - 1);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, IN_USE} role_t;
    typedef enum logic [1:0] {start_s, run_s, diverged_s} state_t;

    state_t              r_state, w_state_next;
    role_t               r_role [2];
    logic [kAngleW-1:0]  r_tag [2];
    logic                r_spare;
    logic [kAW-1:0]      r_fill_addr;
    logic [kAngleW-1:0]  r_fill_angle;
    logic [kAngleW-1:0]  r_pr_angle;
    logic                r_ack_q;
    logic                r_sel0_q, r_sel1_q, r_ok0_q, r_ok1_q;

    logic                w_cur, w_sel1, w_ok0, w_ok1, w_in0, w_in1;
    logic                w_fill_ok, w_wr, w_spare_full, w_has_next;
    logic                w_rel_ack, w_next_ack, w_take, w_swap, w_free_cur, w_free_prev;
    logic [kAW-1:0]      w_idx0, w_idx1;
    logic [kDataW-1:0]   w_rd0 [2];
    logic [kDataW-1:0]   w_rd1 [2];

    // The current bank is always the one that is not the spare.
    assign w_cur        = ~r_spare;
    assign w_fill_ok    = (r_role[r_spare] == EMPTY) || (r_role[r_spare] == FILLING);
    assign w_wr         = fl_valid && w_fill_ok;
    assign w_spare_full = (r_role[r_spare] == FULL);
    assign w_has_next   = (r_role[w_cur] == IN_USE) && (r_pr_angle != kLastAngle);
    assign w_idx0       = pr0_s_val[kAW-1:0];
    assign w_idx1       = pr1_s_val[kAW-1:0];
    assign w_sel1       = (r_state == diverged_s) ? r_spare : w_cur;

`ifdef NABP_FR_RANGE_CHECK_EN
    localparam logic [kSW-1:0] kDepthS = kSW'(kDepth);
    assign w_in0 = !pr0_s_val[kSW-1] && ($unsigned(pr0_s_val) < kDepthS);
    assign w_in1 = !pr1_s_val[kSW-1] && ($unsigned(pr1_s_val) < kDepthS);
`else
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{pr0_s_val[kSW-1:kAW], pr1_s_val[kSW-1:kAW]};
    assign w_in0 = 1'b1;
    assign w_in1 = 1'b1;
`endif

    assign w_ok0 = (r_role[w_cur] == IN_USE) && w_in0;
    assign w_ok1 = (r_role[w_sel1] == IN_USE) && w_in1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [kDataW-1:0] r_mem [kDepth];
        logic [kDataW-1:0] r_rd0, r_rd1;

        always_ff @(posedge clk) begin
            if (w_wr && (r_spare == 1'(gi)))
                r_mem[r_fill_addr] <= fl_val;
            r_rd0 <= r_mem[w_idx0];
            r_rd1 <= r_mem[w_idx1];
        end

        assign w_rd0[gi] = r_rd0;
        assign w_rd1[gi] = r_rd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= start_s;
        else          r_state <= w_state_next;
    end

    // Acks are combinational so a grant can follow the FULL edge directly; r_ack_q forbids back-to-back grants.
    always_comb begin
        w_state_next = r_state;
        w_rel_ack    = 1'b0;
        w_next_ack   = 1'b0;
        w_take       = 1'b0;
        w_swap       = 1'b0;
        w_free_cur   = 1'b0;
        w_free_prev  = 1'b0;
        case (r_state)
            start_s: begin
                if (pr_prev_angle_release && w_spare_full && !r_ack_q) begin
                    w_rel_ack    = 1'b1;
                    w_take       = 1'b1;
                    w_state_next = run_s;
                end
            end
            run_s: begin
                if (w_has_next) begin
                    if (pr_next_angle && w_spare_full && !r_ack_q) begin
                        w_next_ack   = 1'b1;
                        w_swap       = 1'b1;
                        w_state_next = diverged_s;
                    end
                end else if (pr_prev_angle_release) begin
                    w_free_cur   = 1'b1;
                    w_state_next = start_s;
                end
            end
            diverged_s: begin
                if (pr_prev_angle_release && !r_ack_q) begin
                    w_rel_ack    = 1'b1;
                    w_free_prev  = 1'b1;
                    w_state_next = run_s;
                end
            end
            default: w_state_next = start_s;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                r_role[i] <= EMPTY;
                r_tag[i]  <= '0;
            end
            r_spare      <= 1'b0;
            r_fill_addr  <= '0;
            r_fill_angle <= '0;
            r_pr_angle   <= '0;
            r_ack_q      <= 1'b0;
            r_sel0_q     <= 1'b0;
            r_sel1_q     <= 1'b0;
            r_ok0_q      <= 1'b0;
            r_ok1_q      <= 1'b0;
        end else begin
            r_ack_q  <= w_rel_ack | w_next_ack;
            r_sel0_q <= w_cur;
            r_sel1_q <= w_sel1;
            r_ok0_q  <= w_ok0;
            r_ok1_q  <= w_ok1;
            if (w_wr) begin
                if (r_fill_addr == kLastAddr) begin
                    r_role[r_spare] <= FULL;
                    r_tag[r_spare]  <= r_fill_angle;
                    r_fill_addr     <= '0;
                    r_fill_angle    <= (r_fill_angle == kLastAngle) ? '0 : r_fill_angle + kAngleW'(1);
                end else begin
                    r_role[r_spare] <= FILLING;
                    r_fill_addr     <= r_fill_addr + kAW'(1);
                end
            end
            // The full spare becomes current; the old current is either discarded or kept as prev.
            if (w_take || w_swap) begin
                r_role[r_spare] <= IN_USE;
                r_pr_angle      <= r_tag[r_spare];
                r_spare         <= ~r_spare;
                if (w_take)
                    r_role[w_cur] <= EMPTY;
            end
            if (w_free_cur)
                r_role[w_cur] <= EMPTY;
            if (w_free_prev)
                r_role[r_spare] <= EMPTY;
        end
    end

    assign fl_ready                  = w_fill_ok;
    assign pr_angle                  = r_pr_angle;
    assign pr_has_next_angle         = w_has_next;
    assign pr_next_angle_ack         = w_next_ack;
    assign pr_prev_angle_release_ack = w_rel_ack;
    assign pr0_val                   = r_ok0_q ? w_rd0[r_sel0_q] : '0;
    assign pr1_val                   = r_ok1_q ? w_rd1[r_sel1_q] : '0;
endmodule

// File: tb/tb_nabp_filtered_ram_swap_control.sv
// Self-checking bench: directed sweep sequences, a read-routing table and a randomized run
// against a projection-level reference model.
module tb_nabp_filtered_ram_swap_control;
    localparam int kDataW  = 12;
    localparam int kSW     = 6;
    localparam int kDepth  = 8;
    localparam int kAngleW = 8;
    localparam int kN      = 3;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [kDataW-1:0]        fl_val;
    logic                     fl_valid;
    logic                     fl_ready;
    logic [kAngleW-1:0]       pr_angle;
    logic                     pr_has_next_angle;
    logic                     pr_next_angle;
    logic                     pr_next_angle_ack;
    logic                     pr_prev_angle_release;
    logic                     pr_prev_angle_release_ack;
    logic signed [kSW-1:0]    pr0_s_val, pr1_s_val;
    logic signed [kDataW-1:0] pr0_val, pr1_val;

    nabp_filtered_ram_swap_control #(
        .kDataW(kDataW), .kSW(kSW), .kDepth(kDepth), .kAngleW(kAngleW), .kNoOfAngles(kN)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .fl_val(fl_val), .fl_valid(fl_valid), .fl_ready(fl_ready),
        .pr_angle(pr_angle), .pr_has_next_angle(pr_has_next_angle),
        .pr_next_angle(pr_next_angle), .pr_next_angle_ack(pr_next_angle_ack),
        .pr_prev_angle_release(pr_prev_angle_release),
        .pr_prev_angle_release_ack(pr_prev_angle_release_ack),
        .pr0_s_val(pr0_s_val), .pr1_s_val(pr1_s_val),
        .pr0_val(pr0_val), .pr1_val(pr1_val)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Writes samples base+i+1 for fill positions first..last, one per cycle.
    task automatic fill(input int base, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            fl_valid = 1'b1;
            fl_val   = kDataW'(base + i + 1);
            next_cycle();
        end
        fl_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_fl_ready"}, fl_ready, 1);
        chk({tag, "_pr_angle"}, pr_angle, 0);
        chk({tag, "_has_next"}, pr_has_next_angle, 0);
        chk({tag, "_rel_ack"}, pr_prev_angle_release_ack, 0);
        chk({tag, "_next_ack"}, pr_next_angle_ack, 0);
        chk({tag, "_pr0_val"}, pr0_val, 0);
        chk({tag, "_pr1_val"}, pr1_val, 0);
    endtask

    typedef struct {
        logic signed [kSW-1:0] a0;
        logic signed [kSW-1:0] a1;
        int                    e0;
        int                    e1;
    } rd_vec_t;
    rd_vec_t tbl [4];

    // Reference model, in terms of whole projections rather than banks.
    int  m_phase;            // 0 waiting for first angle, 1 single projection, 2 two projections live
    int  fill_q[$];
    int  m_fill_angle;
    bit  rdy_v;
    int  rdy_data [kDepth];
    int  rdy_angle;
    bit  cur_v;
    int  cur_data [kDepth];
    int  prev_data [kDepth];
    int  m_angle;
    bit  last_ack;
    int  exp_p0, exp_p1;

    function automatic int model_read(input bit ok, input int d [kDepth], input logic signed [kSW-1:0] a);
        if (!ok) return 0;
`ifdef NABP_FR_RANGE_CHECK_EN
        if (a < 0 || a >= kDepth) return 0;
`endif
        return d[int'(a) & (kDepth - 1)];
    endfunction

    initial begin
        bit e_ready, e_has_next, e_rel, e_next, e_free;
        int n0, n1;

        reset_n = 1'b0; fl_val = '0; fl_valid = 1'b0; pr_next_angle = 1'b0;
        pr_prev_angle_release = 1'b0; pr0_s_val = '0; pr1_s_val = '0;

        tbl[0] = '{kSW'(0), kSW'(0), 11, 1};
        tbl[1] = '{kSW'(7), kSW'(7), 18, 8};
        tbl[2] = '{kSW'(3), kSW'(5), 14, 6};
`ifdef NABP_FR_RANGE_CHECK_EN
        tbl[3] = '{kSW'(-1), kSW'(8), 0, 0};
`else
        tbl[3] = '{kSW'(-1), kSW'(8), 18, 1};
`endif

        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        next_cycle();

        // First projection with release held: grant in the first cycle after FULL.
        pr_prev_angle_release = 1'b1;
        fill(0, 0, 6);
        #1 chk("rel_ack_while_filling", pr_prev_angle_release_ack, 0);
        fill(0, 7, 7);
        #1 chk("rel_ack_after_full", pr_prev_angle_release_ack, 1);
        next_cycle();
        pr_prev_angle_release = 1'b0;
        pr0_s_val = kSW'(3);
        #1;
        chk("a0_rel_ack_single", pr_prev_angle_release_ack, 0);
        chk("a0_pr_angle", pr_angle, 0);
        chk("a0_has_next", pr_has_next_angle, 1);
        chk("a0_fl_ready", fl_ready, 1);
        next_cycle();
        #1 chk("a0_read_addr3", pr0_val, 4);
        $display("step: angle 0 loaded");

        // Advance request held before angle 1 is complete.
        pr_next_angle = 1'b1;
        fill(10, 0, 6);
        #1 chk("next_ack_before_full", pr_next_angle_ack, 0);
        fill(10, 7, 7);
        #1 chk("next_ack_after_full", pr_next_angle_ack, 1);
        next_cycle();
        pr_next_angle = 1'b0;
        #1;
        chk("div_pr_angle", pr_angle, 1);
        chk("div_fl_ready", fl_ready, 0);
        chk("div_next_ack_single", pr_next_angle_ack, 0);
        for (int i = 0; i < 4; i++) begin
            pr0_s_val = tbl[i].a0;
            pr1_s_val = tbl[i].a1;
            next_cycle();
            #1;
            chk($sformatf("div_port0_vec%0d", i), pr0_val, tbl[i].e0);
            chk($sformatf("div_port1_vec%0d", i), pr1_val, tbl[i].e1);
        end
        $display("step: diverged reads done");

        pr_prev_angle_release = 1'b1;
        #1 chk("div_rel_ack", pr_prev_angle_release_ack, 1);
        next_cycle();
        pr_prev_angle_release = 1'b0;
        pr0_s_val = kSW'(2);
        pr1_s_val = kSW'(5);
        #1;
        chk("run_fl_ready", fl_ready, 1);
        chk("run_rel_ack_single", pr_prev_angle_release_ack, 0);
        next_cycle();
        #1;
        chk("run_port0", pr0_val, 13);
        chk("run_port1", pr1_val, 16);

        // Angle 2 with release already held: release grant must not follow the advance grant directly.
        pr_next_angle = 1'b1;
        pr_prev_angle_release = 1'b1;
        fill(20, 0, 7);
        #1;
        chk("a2_next_ack", pr_next_angle_ack, 1);
        chk("a2_rel_ack_same_cycle", pr_prev_angle_release_ack, 0);
        next_cycle();
        pr_next_angle = 1'b0;
        #1;
        chk("rel_ack_not_back_to_back", pr_prev_angle_release_ack, 0);
        chk("a2_pr_angle", pr_angle, 2);
        next_cycle();
        #1 chk("a2_rel_ack_delayed", pr_prev_angle_release_ack, 1);
        next_cycle();
        pr_prev_angle_release = 1'b0;
        #1;
        chk("last_angle_has_next", pr_has_next_angle, 0);
        chk("last_angle_fl_ready", fl_ready, 1);

        // Next sweep starts filling; advance requests are ignored on the last angle.
        pr_next_angle = 1'b1;
        fill(30, 0, 7);
        #1;
        chk("next_ignored_last_angle", pr_next_angle_ack, 0);
        chk("spare_full_fl_ready", fl_ready, 0);
        next_cycle();
        pr_next_angle = 1'b0;
        pr_prev_angle_release = 1'b1;
        pr0_s_val = kSW'(0);
        #1 chk("end_of_sweep_no_ack", pr_prev_angle_release_ack, 0);
        next_cycle();
        #1;
        chk("new_sweep_rel_ack", pr_prev_angle_release_ack, 1);
        chk("start_has_next", pr_has_next_angle, 0);
        next_cycle();
        pr_prev_angle_release = 1'b0;
        #1;
        chk("new_sweep_pr_angle", pr_angle, 0);
        chk("new_sweep_has_next", pr_has_next_angle, 1);
        chk("read_empty_bank", pr0_val, 0);
        next_cycle();
        #1 chk("new_sweep_read0", pr0_val, 31);
        $display("step: sweep wrap done");

        // Asynchronous reset with the fill pointer at 5.
        fill(40, 0, 4);
        #2 reset_n = 1'b0;
        #1 chk_reset_outputs("midfill_reset");
        @(negedge clk);
        reset_n = 1'b1;
        next_cycle();
        pr_prev_angle_release = 1'b1;
        fill(50, 0, 7);
        #1 chk("refill_rel_ack", pr_prev_angle_release_ack, 1);
        next_cycle();
        pr_prev_angle_release = 1'b0;
        pr0_s_val = kSW'(0);
        next_cycle();
        #1;
        chk("refill_addr0", pr0_val, 51);
        chk("refill_pr_angle", pr_angle, 0);
        $display("step: mid-fill reset done");

        // Randomized run against the model.
        reset_n = 1'b0;
        fl_valid = 1'b0; pr_next_angle = 1'b0; pr_prev_angle_release = 1'b0;
        #3;
        @(negedge clk);
        reset_n = 1'b1;
        m_phase = 0; fill_q.delete(); m_fill_angle = 0; rdy_v = 0; rdy_angle = 0;
        cur_v = 0; m_angle = 0; last_ack = 0; exp_p0 = 0; exp_p1 = 0;
        next_cycle();
        for (int c = 0; c < 3000; c++) begin
            fl_valid              = ($urandom % 4) != 0;
            fl_val                = kDataW'($urandom);
            pr_prev_angle_release = ($urandom % 3) == 0;
            pr_next_angle         = ($urandom % 2) == 0;
            pr0_s_val             = kSW'($urandom);
            pr1_s_val             = kSW'($urandom);
            #1;
            e_ready    = (m_phase != 2) && !rdy_v;
            e_has_next = cur_v && (m_angle != kN - 1);
            e_rel      = !last_ack && pr_prev_angle_release && ((m_phase == 0 && rdy_v) || m_phase == 2);
            e_next     = !last_ack && (m_phase == 1) && e_has_next && pr_next_angle && rdy_v;
            e_free     = (m_phase == 1) && !e_has_next && pr_prev_angle_release;
            chk("rnd_fl_ready", fl_ready, e_ready);
            chk("rnd_has_next", pr_has_next_angle, e_has_next);
            chk("rnd_rel_ack", pr_prev_angle_release_ack, e_rel);
            chk("rnd_next_ack", pr_next_angle_ack, e_next);
            chk("rnd_pr_angle", pr_angle, m_angle);
            chk("rnd_pr0_val", pr0_val, exp_p0);
            chk("rnd_pr1_val", pr1_val, exp_p1);
            n0 = model_read(cur_v, cur_data, pr0_s_val);
            n1 = (m_phase == 2) ? model_read(1'b1, prev_data, pr1_s_val)
                                : model_read(cur_v, cur_data, pr1_s_val);
            @(posedge clk);
            exp_p0 = n0;
            exp_p1 = n1;
            if (e_rel && m_phase == 0) begin
                cur_data = rdy_data; cur_v = 1; m_angle = rdy_angle; rdy_v = 0; m_phase = 1;
            end else if (e_next) begin
                prev_data = cur_data; cur_data = rdy_data; m_angle = rdy_angle; rdy_v = 0; m_phase = 2;
            end else if (e_rel && m_phase == 2) begin
                m_phase = 1;
            end else if (e_free) begin
                cur_v = 0; m_phase = 0;
            end
            if (fl_valid && e_ready) begin
                fill_q.push_back(int'($signed(fl_val)));
                if (fill_q.size() == kDepth) begin
                    for (int i = 0; i < kDepth; i++) rdy_data[i] = fill_q[i];
                    fill_q.delete();
                    rdy_v = 1;
                    rdy_angle = m_fill_angle;
                    m_fill_angle = (m_fill_angle + 1) % kN;
                end
            end
            last_ack = e_rel || e_next;
            #1;
        end
        $display("step: random run done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
